// File: rtl/alu_issue_ctrl_if.sv
// rtl/alu_issue_ctrl_if.sv - issue, register-file and ALU signal bundle for alu_issue_ctrl
interface alu_issue_ctrl_if #(
  parameter int REG_AW = 3
);
  logic              issue_valid;
  logic              issue_ready;
  logic [5:0]        issue_opcode;
  logic [REG_AW-1:0] issue_dst;
  logic [REG_AW-1:0] issue_src;
  logic [15:0]       issue_imm;
  logic [REG_AW-1:0] rf_rd_addr_a;
  logic [REG_AW-1:0] rf_rd_addr_b;
  logic [15:0]       rf_rd_data_a;
  logic [15:0]       rf_rd_data_b;
  logic              alu_start;
  logic [15:0]       alu_op1;
  logic [15:0]       alu_op2;
  logic [5:0]        alu_control;
  logic [15:0]       alu_out;
  logic [3:0]        alu_flags;
  logic              alu_done;
  logic              rf_we;
  logic [REG_AW-1:0] rf_wr_addr;
  logic [15:0]       rf_wr_data;

  // master is the issue controller; slave is decode + register file + ALU
  modport master (
    input  issue_valid, issue_opcode, issue_dst, issue_src, issue_imm,
    input  rf_rd_data_a, rf_rd_data_b, alu_out, alu_flags, alu_done,
    output issue_ready, rf_rd_addr_a, rf_rd_addr_b,
    output alu_start, alu_op1, alu_op2, alu_control,
    output rf_we, rf_wr_addr, rf_wr_data
  );

  modport slave (
    output issue_valid, issue_opcode, issue_dst, issue_src, issue_imm,
    output rf_rd_data_a, rf_rd_data_b, alu_out, alu_flags, alu_done,
    input  issue_ready, rf_rd_addr_a, rf_rd_addr_b,
    input  alu_start, alu_op1, alu_op2, alu_control,
    input  rf_we, rf_wr_addr, rf_wr_data
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - single-instruction ALU issue controller (read, start/done, write-back)
module alu_issue_ctrl #(
  parameter int REG_AW  = 3,
  parameter int TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_issue_ctrl_if.master     bus,
  output logic [3:0]           flags,
  output logic                 done,
  output logic                 error
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

  state_t            state_q, state_d;
  logic [5:0]        opc_q, opc_d;
  logic [REG_AW-1:0] dst_q, dst_d, src_q, src_d;
  logic [15:0]       imm_q, imm_d;
  logic [15:0]       op1_q, op1_d, op2_q, op2_d;
  logic [5:0]        ctl_q, ctl_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [15:0]       res_q, res_d;
  logic [3:0]        aflags_q, aflags_d, flags_q, flags_d;
  logic              err_q, err_d;
  logic              ready_c, start_c, we_c, done_c;
  logic [15:0]       op2_sel;
  logic              bad_op, no_write;

  function automatic logic is_legal(input logic [5:0] op);
    return (op >= 6'd11 && op <= 6'd28) || (op >= 6'd43 && op <= 6'd55) ||
           (op >= 6'd57 && op <= 6'd60);
  endfunction

  always_comb begin
    op2_sel  = opc_q[5] ? imm_q : bus.rf_rd_data_b;
    bad_op   = !is_legal(opc_q) ||
               ((opc_q inside {6'b010011, 6'b110011, 6'b010100, 6'b110100}) && op2_sel == 16'd0) ||
               (opc_q == 6'b111011 && (bus.rf_rd_data_a == 16'd0 || bus.rf_rd_data_a[15]));
    // compare and test forms only update flags
    no_write = ctl_q inside {6'b011001, 6'b111001, 6'b011010, 6'b111010};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      opc_q    <= '0;
      dst_q    <= '0;
      src_q    <= '0;
      imm_q    <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      ctl_q    <= '0;
      cnt_q    <= '0;
      res_q    <= '0;
      aflags_q <= '0;
      flags_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      opc_q    <= opc_d;
      dst_q    <= dst_d;
      src_q    <= src_d;
      imm_q    <= imm_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      ctl_q    <= ctl_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      aflags_q <= aflags_d;
      flags_q  <= flags_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    opc_d    = opc_q;
    dst_d    = dst_q;
    src_d    = src_q;
    imm_d    = imm_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    ctl_d    = ctl_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    aflags_d = aflags_q;
    flags_d  = flags_q;
    err_d    = 1'b0;
    ready_c  = 1'b0;
    start_c  = 1'b0;
    we_c     = 1'b0;
    done_c   = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready_c = 1'b1;
        if (bus.issue_valid) begin
          opc_d   = bus.issue_opcode;
          dst_d   = bus.issue_dst;
          src_d   = bus.issue_src;
          imm_d   = bus.issue_imm;
          state_d = S_READ;
        end
      end
      S_READ: begin
        if (bad_op) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          op1_d   = bus.rf_rd_data_a;
          op2_d   = op2_sel;
          ctl_d   = opc_q;
          cnt_d   = '0;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        start_c = 1'b1;
        // a done in the last allowed cycle still wins over the timeout
        if (bus.alu_done) begin
          res_d    = bus.alu_out;
          aflags_d = bus.alu_flags;
          state_d  = S_WB;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WB: begin
        done_c  = 1'b1;
        we_c    = !no_write;
        flags_d = aflags_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.issue_ready  = ready_c;
  assign bus.rf_rd_addr_a = dst_q;
  assign bus.rf_rd_addr_b = src_q;
  assign bus.alu_start    = start_c;
  assign bus.alu_op1      = op1_q;
  assign bus.alu_op2      = op2_q;
  assign bus.alu_control  = ctl_q;
  assign bus.rf_we        = we_c;
  assign bus.rf_wr_addr   = dst_q;
  assign bus.rf_wr_data   = res_q;
  assign flags            = flags_q;
  assign done             = done_c;
  assign error            = err_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - directed scoreboard bench for alu_issue_ctrl
module tb_alu_issue_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_issue_ctrl_if #(.REG_AW(3)) bus();
  logic [3:0] flags;
  logic       done, error;

  alu_issue_ctrl #(.REG_AW(3), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .bus(bus), .flags(flags), .done(done), .error(error)
  );

  logic [15:0] rf [8];
  int          alu_lat = 0;
  logic [15:0] alu_out_v = '0;
  logic [3:0]  alu_flags_v = '0;
  int          exec_cnt = 0;

  assign bus.rf_rd_data_a = rf[bus.rf_rd_addr_a];
  assign bus.rf_rd_data_b = rf[bus.rf_rd_addr_b];
  assign bus.alu_done     = bus.alu_start && (exec_cnt == alu_lat);
  assign bus.alu_out      = alu_out_v;
  assign bus.alu_flags    = alu_flags_v;

  always @(posedge clk) begin
    exec_cnt <= bus.alu_start ? exec_cnt + 1 : 0;
    if (bus.rf_we) rf[bus.rf_wr_addr] = bus.rf_wr_data;
  end

  typedef struct packed {
    logic        is_err;
    logic        we;
    logic [2:0]  addr;
    logic [15:0] data;
    logic [3:0]  fl;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   checks = 0, errors = 0;
  int   start_cnt = 0, we_cnt = 0, done_cnt = 0, err_cnt = 0;
  logic pend = 1'b0;
  logic [3:0] pend_f = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic is_err, input logic we, input logic [2:0] addr,
                      input logic [15:0] data, input logic [3:0] fl);
    exp_t x;
    x.is_err = is_err; x.we = we; x.addr = addr; x.data = data; x.fl = fl;
    sbq.push_back(x);
  endtask

  always @(negedge clk) begin
    if (pend) begin
      chk("flags_after_end", {28'd0, flags}, {28'd0, pend_f});
      pend = 1'b0;
    end
    if (bus.alu_start) start_cnt++;
    if (bus.rf_we) we_cnt++;
    if (done) done_cnt++;
    if (error) err_cnt++;
    if (done || error) begin
      chk("done_error_exclusive", 32'(done && error), 32'd0);
      if (sbq.size() == 0) chk("sb_underflow", 32'(sbq.size()), 32'd1);
      else begin
        e = sbq.pop_front();
        chk("sb_is_error", 32'(error), 32'(e.is_err));
        if (done) begin
          chk("sb_rf_we", 32'(bus.rf_we), 32'(e.we));
          if (e.we) begin
            chk("sb_wr_addr", 32'(bus.rf_wr_addr), 32'(e.addr));
            chk("sb_wr_data", 32'(bus.rf_wr_data), 32'(e.data));
          end
        end
        pend   = 1'b1;
        pend_f = e.fl;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clr_cnt();
    start_cnt = 0; we_cnt = 0; done_cnt = 0; err_cnt = 0;
  endtask

  task automatic issue(input logic [5:0] opc, input logic [2:0] dst, input logic [2:0] src,
                       input logic [15:0] imm);
    bus.issue_opcode = opc;
    bus.issue_dst    = dst;
    bus.issue_src    = src;
    bus.issue_imm    = imm;
    bus.issue_valid  = 1'b1;
  endtask

  task automatic wait_end(input string tag);
    logic got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      tick();
      got = done || error;
    end
    chk(tag, 32'(got), 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    bus.issue_valid = 1'b0; bus.issue_opcode = '0; bus.issue_dst = '0;
    bus.issue_src = '0; bus.issue_imm = '0;
    for (int i = 0; i < 8; i++) rf[i] = 16'd0;
    rf[1] = 16'h0005; rf[2] = 16'h0003;
    tick(); tick(); tick();
    chk("rst_ready", 32'(bus.issue_ready), 32'd1);
    chk("rst_start", 32'(bus.alu_start), 32'd0);
    chk("rst_rf_we", 32'(bus.rf_we), 32'd0);
    chk("rst_done_err", 32'({done, error}), 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_ops", {bus.alu_op1, bus.alu_op2}, 32'd0);
    chk("rst_ctl_wdata", {10'd0, bus.alu_control, bus.rf_wr_data}, 32'd0);
    reset = 1'b0;
    tick();

    // ADDR r1 += r2, immediate done
    alu_lat = 0; alu_out_v = 16'h0008; alu_flags_v = 4'b0000;
    push(1'b0, 1'b1, 3'd1, 16'h0008, 4'b0000);
    issue(6'b001011, 3'd1, 3'd2, 16'h0000);
    chk("addr_c0_ready", 32'(bus.issue_ready), 32'd1);
    tick(); bus.issue_valid = 1'b0;
    chk("addr_c1_ready", 32'(bus.issue_ready), 32'd0);
    chk("addr_c1_start", 32'(bus.alu_start), 32'd0);
    chk("addr_c1_rdaddr", 32'({bus.rf_rd_addr_a, bus.rf_rd_addr_b}), 32'({3'd1, 3'd2}));
    tick();
    chk("addr_c2_start", 32'(bus.alu_start), 32'd1);
    chk("addr_c2_ops", {bus.alu_op1, bus.alu_op2}, {16'h0005, 16'h0003});
    chk("addr_c2_ctl", 32'(bus.alu_control), 32'h0b);
    tick();
    chk("addr_c3_done", 32'(done), 32'd1);
    chk("addr_c3_we", 32'(bus.rf_we), 32'd1);
    tick();
    chk("addr_c4_ready", 32'(bus.issue_ready), 32'd1);
    chk("addr_c4_start", 32'(bus.alu_start), 32'd0);
    chk("addr_rf1", 32'(rf[1]), 32'h0008);

    // CMPI r3 vs 7: flags only
    clr_cnt();
    rf[3] = 16'h0007; alu_out_v = 16'h0000; alu_flags_v = 4'b1000;
    push(1'b0, 1'b0, 3'd3, 16'h0000, 4'b1000);
    issue(6'b111001, 3'd3, 3'd0, 16'h0007);
    tick(); bus.issue_valid = 1'b0;
    wait_end("cmpi_end_seen");
    tick();
    chk("cmpi_we_cnt", 32'(we_cnt), 32'd0);
    chk("cmpi_done_cnt", 32'(done_cnt), 32'd1);
    chk("cmpi_flags", 32'(flags), 32'h8);
    chk("cmpi_rf3", 32'(rf[3]), 32'h0007);

    // operand-check errors: DIVI by zero, illegal opcode, LOG of negative
    rf[4] = 16'h8000;
    for (int k = 0; k < 3; k++) begin
      logic [5:0] eop;
      logic [2:0] edst;
      eop  = (k == 0) ? 6'b110011 : (k == 1) ? 6'b000001 : 6'b111011;
      edst = (k == 2) ? 3'd4 : 3'd1;
      clr_cnt();
      push(1'b1, 1'b0, 3'd0, 16'h0000, 4'b1000);
      issue(eop, edst, 3'd2, 16'h0000);
      tick(); bus.issue_valid = 1'b0;
      tick();
      chk($sformatf("err%0d_c2_error", k), 32'(error), 32'd1);
      chk($sformatf("err%0d_c2_ready", k), 32'(bus.issue_ready), 32'd1);
      tick();
      chk($sformatf("err%0d_start_cnt", k), 32'(start_cnt), 32'd0);
      chk($sformatf("err%0d_we_cnt", k), 32'(we_cnt), 32'd0);
      chk($sformatf("err%0d_flags", k), 32'(flags), 32'h8);
      chk($sformatf("err%0d_rf", k), 32'(rf[edst]), (k == 2) ? 32'h8000 : 32'h0008);
    end

    // timeout after 15 EXEC cycles without done
    clr_cnt();
    alu_lat = 99;
    push(1'b1, 1'b0, 3'd0, 16'h0000, 4'b1000);
    issue(6'b001011, 3'd1, 3'd2, 16'h0000);
    tick(); bus.issue_valid = 1'b0;
    for (int c = 2; c <= 16; c++) tick();
    chk("to_c16_err_cnt", 32'(err_cnt), 32'd0);
    chk("to_c16_start_cnt", 32'(start_cnt), 32'd15);
    tick();
    chk("to_c17_error", 32'(error), 32'd1);
    chk("to_c17_ready", 32'(bus.issue_ready), 32'd1);
    chk("to_c17_start", 32'(bus.alu_start), 32'd0);
    tick();
    chk("to_we_cnt", 32'(we_cnt), 32'd0);
    chk("to_rf1", 32'(rf[1]), 32'h0008);

    // done on third EXEC cycle
    clr_cnt();
    alu_lat = 2; rf[5] = 16'h1234; rf[6] = 16'h1111;
    alu_out_v = 16'h2345; alu_flags_v = 4'b0010;
    push(1'b0, 1'b1, 3'd5, 16'h2345, 4'b0010);
    issue(6'b001011, 3'd5, 3'd6, 16'h0000);
    tick(); bus.issue_valid = 1'b0;
    for (int c = 2; c <= 4; c++) begin
      tick();
      chk($sformatf("late_c%0d_ops", c), {bus.alu_op1, bus.alu_op2}, {16'h1234, 16'h1111});
      chk($sformatf("late_c%0d_start_done", c), 32'({bus.alu_start, done}), 32'b10);
    end
    tick();
    chk("late_c5_done", 32'(done), 32'd1);
    tick();
    chk("late_flags", 32'(flags), 32'h2);
    chk("late_rf5", 32'(rf[5]), 32'h2345);
    chk("late_start_cnt", 32'(start_cnt), 32'd3);

    // reset during EXEC aborts, then ADDI completes
    clr_cnt();
    alu_lat = 99;
    issue(6'b001011, 3'd1, 3'd2, 16'h0000);
    tick(); bus.issue_valid = 1'b0;
    tick(); tick();
    chk("rx_c3_start", 32'(bus.alu_start), 32'd1);
    reset = 1'b1;
    tick();
    chk("rx_ready", 32'(bus.issue_ready), 32'd1);
    chk("rx_start", 32'(bus.alu_start), 32'd0);
    chk("rx_flags", 32'(flags), 32'd0);
    chk("rx_rf_we", 32'(bus.rf_we), 32'd0);
    chk("rx_op1", 32'(bus.alu_op1), 32'd0);
    reset = 1'b0;
    tick();
    chk("rx_we_cnt", 32'(we_cnt), 32'd0);
    chk("rx_rf1", 32'(rf[1]), 32'h0008);
    alu_lat = 0; alu_out_v = 16'h0013; alu_flags_v = 4'b0000;
    push(1'b0, 1'b1, 3'd2, 16'h0013, 4'b0000);
    issue(6'b101011, 3'd2, 3'd0, 16'h0010);
    tick(); bus.issue_valid = 1'b0;
    tick();
    chk("addi_ops", {bus.alu_op1, bus.alu_op2}, {16'h0003, 16'h0010});
    wait_end("addi_end_seen");
    tick();
    chk("addi_rf2", 32'(rf[2]), 32'h0013);

    tick();
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
